// File: rtl/comm_master.sv
// comm_master -- host-side UART command initiator for the logic-analyzer core.
//
// Sends a 16-bit command as two back-to-back 8N1 frames (high byte first) on
// TX and receives 8N1 response bytes on RX. The receiver runs independently of
// the transmitter and is always armed.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   snd_cmd      1-cycle pulse, starts sending cmd (ignored while sending)
//   cmd[15:0]    command word, captured with snd_cmd
//   cmd_cmplt    high once the low byte's stop bit ends; held until next send
//   TX           serial out, idles high, driven straight from a flop
//   RX           serial in, asynchronous to clk
//   resp[7:0]    last correctly framed received byte
//   resp_rdy     resp holds a new byte
//   clr_resp_rdy clears resp_rdy (a simultaneous new byte wins)
module comm_master #(
  parameter int BAUD_DIV = 108  // clk cycles per bit, >= 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        cmd_cmplt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] BAUD_ZERO = '0;
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, DONE} tx_state_e;
  typedef enum logic {R_IDLE, R_RX} rx_state_e;

  // ---------------------------------------------------------------- transmit
  tx_state_e       tx_state_q, tx_state_d;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic [CW-1:0]   tx_baud_q,  tx_baud_d;
  logic [3:0]      tx_bit_q,   tx_bit_d;
  logic [7:0]      cmd_lo_q,   cmd_lo_d;
  logic            tx_q,       tx_d;
  logic            cmd_cmplt_q, cmd_cmplt_d;

  logic tx_bit_end, tx_frame_end;
  assign tx_bit_end   = (tx_baud_q == BAUD_LAST);
  assign tx_frame_end = tx_bit_end && (tx_bit_q == 4'd9);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state_q <= IDLE;
    else        tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      IDLE, DONE: if (snd_cmd)      tx_state_d = TX_HI;
      TX_HI:      if (tx_frame_end) tx_state_d = TX_LO;
      TX_LO:      if (tx_frame_end) tx_state_d = DONE;
      default:                      tx_state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    tx_shift_d  = tx_shift_q;
    tx_baud_d   = tx_baud_q;
    tx_bit_d    = tx_bit_q;
    cmd_lo_d    = cmd_lo_q;
    cmd_cmplt_d = cmd_cmplt_q;
    tx_d        = 1'b1;
    unique case (tx_state_q)
      IDLE, DONE: begin
        if (snd_cmd) begin
          // Frame = {stop, data, start}; bit 0 goes out first.
          tx_shift_d  = {1'b1, cmd[15:8], 1'b0};
          cmd_lo_d    = cmd[7:0];
          tx_baud_d   = BAUD_ZERO;
          tx_bit_d    = 4'd0;
          cmd_cmplt_d = 1'b0;
        end else if (tx_state_q == DONE) begin
          cmd_cmplt_d = 1'b1;
        end
      end
      TX_HI, TX_LO: begin
        // TX lags the shifter by one flop, so the first bit appears one cycle
        // after the command is accepted and each bit still lasts BAUD_DIV.
        tx_d = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_baud_d = BAUD_ZERO;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d   = 4'd0;
            tx_shift_d = {1'b1, cmd_lo_q, 1'b0};  // low byte follows, no gap
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
          end
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q  <= '1;
      tx_baud_q   <= BAUD_ZERO;
      tx_bit_q    <= 4'd0;
      cmd_lo_q    <= 8'h00;
      tx_q        <= 1'b1;
      cmd_cmplt_q <= 1'b0;
    end else begin
      tx_shift_q  <= tx_shift_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      cmd_lo_q    <= cmd_lo_d;
      tx_q        <= tx_d;
      cmd_cmplt_q <= cmd_cmplt_d;
    end
  end

  assign TX        = tx_q;
  assign cmd_cmplt = cmd_cmplt_q;

  // ----------------------------------------------------------------- receive
  logic            rx_meta_q, rx_sync_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_baud_q,  rx_baud_d;
  logic [3:0]      rx_bit_q,   rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      resp_q,     resp_d;
  logic            resp_rdy_q, resp_rdy_d;

  logic rx_sample;
  assign rx_sample = (rx_baud_q == BAUD_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= R_IDLE;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      R_IDLE: if (!rx_sync_q) rx_state_d = R_RX;
      R_RX: begin
        // Leave on a start bit that reads high mid-bit (glitch) or after stop.
        if (rx_sample && ((rx_bit_q == 4'd0 && rx_sync_q) || rx_bit_q == 4'd9))
          rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    resp_d     = resp_q;
    resp_rdy_d = clr_resp_rdy ? 1'b0 : resp_rdy_q;
    unique case (rx_state_q)
      R_IDLE: begin
        if (!rx_sync_q) begin
          rx_baud_d  = BAUD_HALF;  // first sample lands mid start bit
          rx_bit_d   = 4'd0;
          resp_rdy_d = 1'b0;
        end
      end
      R_RX: begin
        if (rx_sample) begin
          rx_baud_d = BAUD_LAST;
          rx_bit_d  = rx_bit_q + 4'd1;
          if (rx_bit_q >= 4'd1 && rx_bit_q <= 4'd8)
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 4'd9 && rx_sync_q) begin
            resp_d     = rx_shift_q;
            resp_rdy_d = 1'b1;  // overrides a same-cycle clear
          end
        end else begin
          rx_baud_d = rx_baud_q - BAUD_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_baud_q  <= BAUD_ZERO;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_comm_master.sv
// Testbench for comm_master: directed and randomized commands and response
// bytes, checked against a frame-level model of 8N1 UART traffic.
module tb_comm_master;

  localparam int B    = 16;
  localparam int NCYC = 20 * B + 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        clr_resp_rdy = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        cmd_cmplt, tx_w, rx_line, resp_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_resp = 8'h00;
  logic       exp_rdy = 1'b0;

  assign rx_line = loop_en ? tx_w : rx_drv;

  always #5 clk = ~clk;

  comm_master #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd),
    .cmd_cmplt(cmd_cmplt), .TX(tx_w), .RX(rx_line),
    .resp(resp), .resp_rdy(resp_rdy), .clr_resp_rdy(clr_resp_rdy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level of bit b (0..19) of the two-frame stream for command c.
  function automatic logic frame_bit(input logic [15:0] c, input int b);
    int p;
    logic [7:0] byt;
    p   = b % 10;
    byt = (b < 10) ? c[15:8] : c[7:0];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return byt[p-1];
  endfunction

  // Sends c, optionally pulsing snd_cmd with ghost_c at cycle ghost_k, and
  // checks the line waveform and cmd_cmplt timing against the frame model.
  task automatic tx_transfer(input logic [15:0] c, input int ghost_k,
                             input logic [15:0] ghost_c, input string tag);
    logic tx_h [NCYC];
    logic cc_h [NCYC];
    int fall, cc_k, errs;
    logic [7:0] hi_b, lo_b;
    @(posedge clk); #1;
    cmd = c;
    snd_cmd = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk); #1;
      tx_h[k] = tx_w;
      cc_h[k] = cmd_cmplt;
      if (k == ghost_k) begin
        snd_cmd = 1'b1;
        cmd = ghost_c;
      end else begin
        snd_cmd = 1'b0;
        cmd = 16'($urandom);
      end
    end
    snd_cmd = 1'b0;
    fall = -1;
    cc_k = -1;
    for (int k = NCYC - 1; k >= 0; k--) begin
      if (tx_h[k] === 1'b0) fall = k;
      if (cc_h[k] === 1'b1) cc_k = k;
    end
    check($sformatf("%s_cc_clear", tag), cc_h[0], 1'b0);
    check($sformatf("%s_fall", tag), fall, 1);
    if (fall >= 0 && fall + 20 * B + 4 <= NCYC) begin
      errs = 0;
      for (int j = fall; j < NCYC; j++) begin
        if (tx_h[j] !== (((j - fall) / B < 20) ? frame_bit(c, (j - fall) / B) : 1'b1))
          errs++;
      end
      for (int i = 0; i < 8; i++) begin
        hi_b[i] = tx_h[fall + (1 + i) * B + B / 2];
        lo_b[i] = tx_h[fall + (11 + i) * B + B / 2];
      end
      check($sformatf("%s_wave_errs", tag), errs, 0);
      check($sformatf("%s_hi_byte", tag), hi_b, c[15:8]);
      check($sformatf("%s_lo_byte", tag), lo_b, c[7:0]);
      check($sformatf("%s_cc_rise", tag), cc_k, fall + 20 * B);
    end
    check($sformatf("%s_cc_held", tag), cc_h[NCYC-1], 1'b1);
  endtask

  // Drives one frame on RX at pct% of the nominal bit time and checks the
  // receiver against the model (resp/resp_rdy and the response latency).
  task automatic rx_send(input logic [7:0] d, input logic stop, input int pct,
                         input logic hold_clr, input string tag);
    int rise_k, idx, lo, hi;
    logic prev;
    rise_k = -1;
    prev = resp_rdy;
    for (int k = 0; k < 12 * B; k++) begin
      @(posedge clk); #1;
      if (k > 0 && resp_rdy === 1'b1 && prev === 1'b0 && rise_k < 0) rise_k = k;
      prev = resp_rdy;
      idx = (k * 100) / (B * pct);
      if (idx == 0)      rx_drv = 1'b0;
      else if (idx <= 8) rx_drv = d[idx-1];
      else if (idx == 9) rx_drv = stop;
      else               rx_drv = 1'b1;
      clr_resp_rdy = hold_clr;
    end
    clr_resp_rdy = 1'b0;
    if (stop) begin
      exp_resp = d;
      exp_rdy  = !hold_clr;
    end else begin
      exp_rdy  = 1'b0;
    end
    lo = (19 * B) / 2 + 2;
    hi = (19 * B) / 2 + 4;
    check($sformatf("%s_rise_seen", tag), (rise_k >= 0), stop);
    if (stop && pct == 100)
      check($sformatf("%s_latency_in_window", tag), (rise_k >= lo && rise_k <= hi), 1'b1);
    check($sformatf("%s_resp", tag), resp, exp_resp);
    check($sformatf("%s_rdy", tag), resp_rdy, exp_rdy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    int pcts [3];
    logic [7:0] d;
    logic stop;
    int pct;
    pcts = '{97, 100, 103};

    // Reset values, then a quiet line.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_w, 1'b1);
    check("rst_cmd_cmplt", cmd_cmplt, 1'b0);
    check("rst_resp_rdy", resp_rdy, 1'b0);
    check("rst_resp", resp, 8'h00);
    rst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (tx_w !== 1'b1) lows++;
    end
    check("idle_tx_lows", lows, 0);

    // Directed command with an ignored snd_cmd in the middle.
    tx_transfer(16'hA5C3, 100, 16'hFFFF, "a5c3");

    // Random commands with randomly timed ignored pulses.
    for (int n = 0; n < 3; n++)
      tx_transfer(16'($urandom), int'($urandom_range(2, 20 * B - 1)), 16'($urandom),
                  $sformatf("rnd_tx%0d", n));

    // Directed receive, then clear.
    rx_send(8'h5A, 1'b1, 100, 1'b0, "rx5a");
    @(posedge clk); #1;
    clr_resp_rdy = 1'b1;
    @(posedge clk); #1;
    clr_resp_rdy = 1'b0;
    exp_rdy = 1'b0;
    check("clr_rdy", resp_rdy, 1'b0);
    check("clr_resp_kept", resp, 8'h5A);

    // Framing error.
    rx_send(8'h3C, 1'b0, 100, 1'b0, "frame_err");

    // Two-cycle glitch on RX.
    begin
      int rises;
      logic prev;
      rises = 0;
      prev = resp_rdy;
      for (int k = 0; k < 12 * B; k++) begin
        @(posedge clk); #1;
        if (resp_rdy === 1'b1 && prev === 1'b0) rises++;
        prev = resp_rdy;
        rx_drv = (k < 2) ? 1'b0 : 1'b1;
      end
      exp_rdy = 1'b0;
      check("glitch_rises", rises, 0);
      check("glitch_resp", resp, exp_resp);
      check("glitch_rdy", resp_rdy, exp_rdy);
    end

    // Random bytes, bit-rate skew, held clear (set must win), framing errors.
    for (int n = 0; n < 5; n++) begin
      d    = 8'($urandom);
      pct  = pcts[$urandom_range(0, 2)];
      stop = (pct != 100) || ($urandom_range(0, 3) != 0);
      rx_send(d, stop, pct, 1'($urandom_range(0, 1)), $sformatf("rnd_rx%0d", n));
    end

    // Reset during the low byte's data bits.
    @(posedge clk); #1;
    cmd = {8'($urandom), 8'h00};
    snd_cmd = 1'b1;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    repeat (14 * B) @(posedge clk);
    #1;
    check("mid_lo_tx_low", tx_w, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_high", tx_w, 1'b1);
    check("mid_rst_cc", cmd_cmplt, 1'b0);
    check("mid_rst_resp", resp, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_resp = 8'h00;
    exp_rdy = 1'b0;

    // Clean command after reset, looped back into the receiver.
    loop_en = 1'b1;
    tx_transfer(16'h0102, -1, 16'h0000, "lb0102");
    repeat (4 * B) @(posedge clk);
    #1;
    check("lb_resp", resp, 8'h02);
    check("lb_rdy", resp_rdy, 1'b1);
    loop_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
